// File: rtl/hash_scan_pkg.sv
// hash_scan_pkg: shared state encoding and bus/report constants
// for the hash result scanner.
package hash_scan_pkg;

    localparam int MEM_AW = 16;
    localparam int MEM_DW = 32;

    localparam int REPORT_WORDS    = 3;
    localparam int REPORT_FLAG_OFS = 0;
    localparam int REPORT_HASH_OFS = 1;
    localparam int REPORT_CNT_OFS  = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        DRAIN,
        WR0,
        WR1,
        WR2,
        DONE
    } scan_state_t;

    function automatic logic [MEM_AW-1:0] word_addr(
        input logic [MEM_AW-1:0] base,
        input int                ofs
    );
        return base + MEM_AW'(ofs);
    endfunction

endpackage

// File: rtl/scan_min_tracker.sv
// scan_min_tracker: running strict minimum (lowest index wins ties)
// and below-target hit counter over a stream of tagged hash words.
module scan_min_tracker
    import hash_scan_pkg::*;
#(
    parameter int IW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              valid,
    input  logic [IW-1:0]     idx,
    input  logic [MEM_DW-1:0] data,
    input  logic [MEM_DW-1:0] target,
    output logic [MEM_DW-1:0] best_hash,
    output logic [IW-1:0]     best_idx,
    output logic [4:0]        hit_count
);

    logic [MEM_DW-1:0] hash_q, hash_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4:0]        cnt_q, cnt_d;

    always_comb begin
        hash_d = hash_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        if (clear) begin
            hash_d = '1;
            idx_d  = '0;
            cnt_d  = '0;
        end else if (valid) begin
            if (data < hash_q) begin
                hash_d = data;
                idx_d  = idx;
            end
            if (data < target) begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hash_q <= '1;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else begin
            hash_q <= hash_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
        end
    end

    assign best_hash = hash_q;
    assign best_idx  = idx_q;
    assign hit_count = cnt_q;

endmodule

// File: rtl/hash_result_scanner.sv
// hash_result_scanner: sweeps the nonce result table, tracks the best
// hash and hit count, then writes a 3-word report over the shared bus.
module hash_result_scanner
    import hash_scan_pkg::*;
#(
    parameter  int NUM_NONCES = 16,
    parameter  int RD_LAT     = 2,
    localparam int IW         = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [MEM_AW-1:0] result_addr,
    input  logic [MEM_AW-1:0] report_addr,
    input  logic [MEM_DW-1:0] target,
    output logic              done,
    output logic              found,
    output logic [IW-1:0]     best_idx,
    output logic [MEM_DW-1:0] best_hash,
    output logic [4:0]        hit_count,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_write_data,
    input  logic [MEM_DW-1:0] mem_read_data
);

    scan_state_t       state_q, state_d;
    logic [IW-1:0]     k_q, k_d;
    logic [MEM_AW-1:0] res_base_q, rep_base_q;
    logic [MEM_DW-1:0] tgt_q;
    logic              found_q, found_d;
    logic              we_q, we_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [MEM_DW-1:0] wdata_q, wdata_d;
    logic [RD_LAT-1:0] vld_q;
    logic [IW-1:0]     tag_q [RD_LAT];
    logic              accept;
    logic              issue;
    logic              meets;

    assign accept = (state_q == IDLE) && start;
    assign issue  = (state_q == RD);
    assign meets  = best_hash < tgt_q;

    scan_min_tracker #(.IW(IW)) u_track (
        .clk       (clk),
        .rst_n     (reset_n),
        .clear     (accept),
        .valid     (vld_q[RD_LAT-1]),
        .idx       (tag_q[RD_LAT-1]),
        .data      (mem_read_data),
        .target    (tgt_q),
        .best_hash (best_hash),
        .best_idx  (best_idx),
        .hit_count (hit_count)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        found_d = found_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    found_d = 1'b0;
                    k_d     = '0;
                    state_d = RD;
                end
            end
            RD: begin
                addr_d = res_base_q + MEM_AW'(k_q);
                k_d    = k_q + 1'b1;
                if (k_q == IW'(NUM_NONCES - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Pipe empty means the last tagged word is already folded in.
                if (vld_q == '0) begin
                    found_d = meets;
                    we_d    = 1'b1;
                    addr_d  = word_addr(rep_base_q, REPORT_FLAG_OFS);
                    wdata_d = {meets, {(MEM_DW-1-IW){1'b0}}, best_idx};
                    state_d = WR0;
                end
            end
            WR0: begin
                we_d    = 1'b1;
                addr_d  = word_addr(rep_base_q, REPORT_HASH_OFS);
                wdata_d = best_hash;
                state_d = WR1;
            end
            WR1: begin
                we_d    = 1'b1;
                addr_d  = word_addr(rep_base_q, REPORT_CNT_OFS);
                wdata_d = {{(MEM_DW-5){1'b0}}, hit_count};
                state_d = WR2;
            end
            WR2: begin
                state_d = DONE;
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            res_base_q <= '0;
            rep_base_q <= '0;
            tgt_q      <= '0;
            found_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            found_q <= found_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (accept) begin
                res_base_q <= result_addr;
                rep_base_q <= report_addr;
                tgt_q      <= target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            for (int s = RD_LAT - 1; s > 0; s--) begin
                vld_q[s] <= vld_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
            vld_q[0] <= issue;
            tag_q[0] <= k_q;
        end
    end

    assign done           = (state_q == DONE);
    assign found          = found_q;
    assign mem_clk        = clk;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_hash_result_scanner.sv
// tb_hash_result_scanner: table-driven scans against a 2-cycle memory
// model, with a queue scoreboard for the report writes.
module tb_hash_result_scanner;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] result_addr = '0;
    logic [15:0] report_addr = '0;
    logic [31:0] target = '0;
    logic        done;
    logic        found;
    logic [3:0]  best_idx;
    logic [31:0] best_hash;
    logic [4:0]  hit_count;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    hash_result_scanner #(.NUM_NONCES(16), .RD_LAT(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .result_addr    (result_addr),
        .report_addr    (report_addr),
        .target         (target),
        .done           (done),
        .found          (found),
        .best_idx       (best_idx),
        .best_hash      (best_hash),
        .hit_count      (hit_count),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Address registered at edge n, data held valid across edge n+2.
    logic [31:0] mem [0:65535];
    logic [31:0] rd_q = '0;
    always @(posedge clk) rd_q <= mem[mem_addr];
    assign mem_read_data = rd_q;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct packed {
        logic [15:0][31:0] tbl;
        logic [15:0]       ra;
        logic [15:0]       wa;
        logic [31:0]       tgt;
        logic              f;
        logic [3:0]        idx;
        logic [31:0]       hash;
        logic [4:0]        hits;
    } vec_t;

    wr_t  wq[$];
    wr_t  exp_w;
    vec_t vecs[5];
    int   total = 0;
    int   bad = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            total++;
            if (wq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_write_data);
            end else begin
                exp_w = wq.pop_front();
                if (exp_w.a !== mem_addr || exp_w.d !== mem_write_data) begin
                    bad++;
                    $display("FAIL report_write got=%h:%h exp=%h:%h",
                             mem_addr, mem_write_data, exp_w.a, exp_w.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_found"}, 32'(found), 32'h0);
        chk({tag, "_idx"}, 32'(best_idx), 32'h0);
        chk({tag, "_hash"}, best_hash, 32'hFFFF_FFFF);
        chk({tag, "_hits"}, 32'(hit_count), 32'h0);
        chk({tag, "_we"}, 32'(mem_we), 32'h0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_wdata"}, mem_write_data, 32'h0);
    endtask

    task automatic load_table(input vec_t v);
        logic [15:0] a;
        for (int i = 0; i < N; i++) begin
            a = v.ra + 16'(i);
            mem[a] = v.tbl[i];
        end
    endtask

    task automatic run_scan(input vec_t v, input int hold);
        int          lat;
        logic [15:0] a;
        wr_t         w;
        load_table(v);
        w.a = v.wa;
        w.d = {v.f, 27'b0, v.idx};
        wq.push_back(w);
        w.a = v.wa + 16'd1;
        w.d = v.hash;
        wq.push_back(w);
        w.a = v.wa + 16'd2;
        w.d = {27'b0, v.hits};
        wq.push_back(w);
        @(negedge clk);
        result_addr = v.ra;
        report_addr = v.wa;
        target      = v.tgt;
        start       = 1'b1;
        @(posedge clk);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (done) break;
            if (lat >= 1 && lat <= N) begin
                a = v.ra + 16'(lat - 1);
                chk("rd_addr", 32'(mem_addr), 32'(a));
            end
            @(posedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd22);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("done_hold", 32'(done), 32'h1);
        end
        chk("found", 32'(found), 32'(v.f));
        chk("best_idx", 32'(best_idx), 32'(v.idx));
        chk("best_hash", best_hash, v.hash);
        chk("hit_count", 32'(hit_count), 32'(v.hits));
        chk("writes_left", 32'(wq.size()), 32'h0);
        wq.delete();
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("done_drop", 32'(done), 32'h0);
        chk("found_kept", 32'(found), 32'(v.f));
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            vecs[0].tbl[i] = 32'h100 + 32'(i);
            vecs[1].tbl[i] = 32'hFFFF_FFFF;
            vecs[2].tbl[i] = (i == 3 || i == 9) ? 32'h10 : 32'h8000_0000;
            vecs[3].tbl[i] = (i == 7) ? 32'h50 : 32'h1000 + 32'(i);
            vecs[4].tbl[i] = 32'h300 - 32'(i);
        end
        vecs[0].ra = 16'h0040; vecs[0].wa = 16'h0200; vecs[0].tgt = 32'h105;
        vecs[0].f = 1'b1; vecs[0].idx = 4'd0; vecs[0].hash = 32'h100; vecs[0].hits = 5'd5;
        vecs[1].ra = 16'h0080; vecs[1].wa = 16'h0210; vecs[1].tgt = 32'h0;
        vecs[1].f = 1'b0; vecs[1].idx = 4'd0; vecs[1].hash = 32'hFFFF_FFFF; vecs[1].hits = 5'd0;
        vecs[2].ra = 16'h00C0; vecs[2].wa = 16'h0220; vecs[2].tgt = 32'hFFFF_FFFF;
        vecs[2].f = 1'b1; vecs[2].idx = 4'd3; vecs[2].hash = 32'h10; vecs[2].hits = 5'd16;
        vecs[3].ra = 16'h0100; vecs[3].wa = 16'h0230; vecs[3].tgt = 32'h50;
        vecs[3].f = 1'b0; vecs[3].idx = 4'd7; vecs[3].hash = 32'h50; vecs[3].hits = 5'd0;
        vecs[4].ra = 16'hFFF8; vecs[4].wa = 16'h0020; vecs[4].tgt = 32'h2F4;
        vecs[4].f = 1'b1; vecs[4].idx = 4'd15; vecs[4].hash = 32'h2F1; vecs[4].hits = 5'd3;

        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("idle");

        run_scan(vecs[0], 0);
        run_scan(vecs[1], 5);
        run_scan(vecs[2], 0);
        run_scan(vecs[3], 2);

        load_table(vecs[4]);
        @(negedge clk);
        result_addr = vecs[4].ra;
        report_addr = vecs[4].wa;
        target      = vecs[4].tgt;
        start       = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        chk_reset("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst_idle_done", 32'(done), 32'h0);
        chk("midrst_idle_we", 32'(mem_we), 32'h0);

        run_scan(vecs[4], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
